hotp_generator: RTL and testbench

// - Parametrised HOTP (RFC 4226) engine with start/busy/done handshake.
// - Registers key and counter, runs an internal HMACSHA1 core, then does dynamic truncation.
// - Converts the 31-bit truncated value to BCD with a sequential double-dabble (no divider).
// - Returns the low DIGITS decimal digits. Sits between the key store / host interface and the display/UART path.

---
 rtl/hotp_generator.sv | 193 +++++++++++++++++++
 tb/tb_hotp_generator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hotp_generator.sv
// HOTP (RFC 4226) engine: HMAC-SHA1 over a registered key/counter, dynamic truncation, double-dabble to BCD.
// Optional build macro COUNTER_AUTOINC_EN: internal auto-incrementing counter, loaded through the `load` port.
module hotp_generator #(
  parameter int DIGITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [511:0]        key,
  input  logic [63:0]         counter,
`ifdef COUNTER_AUTOINC_EN
  input  logic                load,
`endif
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] code_bcd
);

  typedef enum logic [2:0] {IDLE, HASH, TRUNC, CONV, DONE} state_t;

  localparam logic [159:0] SHA1_IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [511:0] IPAD    = {64{8'h36}};
  localparam logic [511:0] OPAD    = {64{8'h5c}};

  state_t         state, state_nxt;
  logic [511:0]   key_reg;
  logic [63:0]    ctr_reg;
  logic [159:0]   h_reg;      // chaining value of the block in flight
  logic [159:0]   v_reg;      // working variables a..e
  logic [511:0]   w_reg;      // 16-word message schedule window, W[t] on top
  logic [159:0]   inner_reg;
  logic [1:0]     blk;
  logic [6:0]     rnd;
  logic [30:0]    num_reg;
  logic [39:0]    bcd_reg;
  logic [4:0]     cnt;
  logic [159:0]   h_sum;
  logic [31:0]    w_new;
  logic [39:0]    bcd_nxt;
  logic [7:0]     trunc_base;

  function automatic logic [159:0] sha1_round(input logic [159:0] v, input logic [31:0] w,
                                              input logic [6:0] t);
    logic [31:0] a, b, c, d, e, f, k, tmp;
    {a, b, c, d, e} = v;
    if (t < 7'd20) begin
      f = (b & c) | (~b & d);
      k = 32'h5A827999;
    end else if (t < 7'd40) begin
      f = b ^ c ^ d;
      k = 32'h6ED9EBA1;
    end else if (t < 7'd60) begin
      f = (b & c) | (b & d) | (c & d);
      k = 32'h8F1BBCDC;
    end else begin
      f = b ^ c ^ d;
      k = 32'hCA62C1D6;
    end
    tmp = {a[26:0], a[31:27]} + f + e + k + w;
    return {tmp, a, {b[1:0], b[31:2]}, c, d};
  endfunction

  // One double-dabble step over ten BCD digits: correct, then shift in the next binary bit.
  function automatic logic [39:0] dabble(input logic [39:0] b, input logic in);
    logic [39:0] a;
    for (int i = 0; i < 10; i++) begin
      a[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    end
    return {a[38:0], in};
  endfunction

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      h_sum[32*i +: 32] = h_reg[32*i +: 32] + v_reg[32*i +: 32];
    end
    w_new      = w_reg[95:64] ^ w_reg[255:224] ^ w_reg[447:416] ^ w_reg[511:480];
    w_new      = {w_new[30:0], w_new[31]};
    bcd_nxt    = dabble(bcd_reg, num_reg[30]);
    trunc_base = {5'd16 - {1'b0, h_reg[3:0]}, 3'b000};
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = HASH;
      HASH: begin
        busy = 1'b1;
        if (rnd == 7'd80 && blk == 2'd3) state_nxt = TRUNC;
      end
      TRUNC: begin
        busy      = 1'b1;
        state_nxt = CONV;
      end
      CONV: begin
        busy = 1'b1;
        if (cnt == 5'd30) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      key_reg   <= '0;
      ctr_reg   <= '0;
      h_reg     <= '0;
      v_reg     <= '0;
      w_reg     <= '0;
      inner_reg <= '0;
      blk       <= '0;
      rnd       <= '0;
      num_reg   <= '0;
      bcd_reg   <= '0;
      cnt       <= '0;
      code_bcd  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
`ifdef COUNTER_AUTOINC_EN
          if (load) ctr_reg <= counter;
`endif
          if (start) begin
            key_reg <= key;
`ifndef COUNTER_AUTOINC_EN
            ctr_reg <= counter;
`endif
            blk     <= 2'd0;
            rnd     <= 7'd0;
            h_reg   <= SHA1_IV;
            v_reg   <= SHA1_IV;
            w_reg   <= key ^ IPAD;
          end
        end
        // Four compressions: K^ipad, counter block, K^opad, inner digest block
        HASH: begin
          if (rnd != 7'd80) begin
            v_reg <= sha1_round(v_reg, w_reg[511:480], rnd);
            w_reg <= {w_reg[479:0], w_new};
            rnd   <= rnd + 7'd1;
          end else begin
            rnd <= 7'd0;
            blk <= blk + 2'd1;
            case (blk)
              2'd0: begin
                h_reg <= h_sum;
                v_reg <= h_sum;
                w_reg <= {ctr_reg, 1'b1, 383'd0, 64'd576};
              end
              2'd1: begin
                inner_reg <= h_sum;
                h_reg     <= SHA1_IV;
                v_reg     <= SHA1_IV;
                w_reg     <= key_reg ^ OPAD;
              end
              2'd2: begin
                h_reg <= h_sum;
                v_reg <= h_sum;
                w_reg <= {inner_reg, 1'b1, 287'd0, 64'd672};
              end
              default: h_reg <= h_sum;
            endcase
          end
        end
        TRUNC: begin
          num_reg <= h_reg[trunc_base +: 31];
          bcd_reg <= '0;
          cnt     <= 5'd0;
        end
        CONV: begin
          bcd_reg <= bcd_nxt;
          num_reg <= {num_reg[29:0], 1'b0};
          cnt     <= cnt + 5'd1;
          if (cnt == 5'd30) code_bcd <= bcd_nxt[4*DIGITS-1:0];
        end
        DONE: begin
`ifdef COUNTER_AUTOINC_EN
          ctr_reg <= ctr_reg + 64'd1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hotp_generator.sv
// Bench for hotp_generator: DIGITS=6/8/10 instances in parallel against a byte-level HMAC-SHA1/HOTP model.
module tb_hotp_generator;

  typedef byte unsigned bytes_t[$];

  localparam logic [159:0] RFC_KEY = "12345678901234567890";
  localparam int           BUSY_CYCLES = 4 * 81 + 1 + 31;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         load = 1'b0;
  logic [511:0] key = '0;
  logic [63:0]  counter = '0;
  logic         busy6, busy8, busy10, done6, done8, done10;
  logic [23:0]  code6;
  logic [31:0]  code8;
  logic [39:0]  code10;
  int           n_tests = 0;
  int           n_fail = 0;
  int           ndone = 0;
  logic [511:0] rfc;

  always #5 clk = ~clk;

  hotp_generator #(.DIGITS(6)) dut6 (
    .clk(clk), .reset(rst_n), .start(start), .key(key), .counter(counter),
`ifdef COUNTER_AUTOINC_EN
    .load(load),
`endif
    .busy(busy6), .done(done6), .code_bcd(code6));

  hotp_generator #(.DIGITS(8)) dut8 (
    .clk(clk), .reset(rst_n), .start(start), .key(key), .counter(counter),
`ifdef COUNTER_AUTOINC_EN
    .load(load),
`endif
    .busy(busy8), .done(done8), .code_bcd(code8));

  hotp_generator #(.DIGITS(10)) dut10 (
    .clk(clk), .reset(rst_n), .start(start), .key(key), .counter(counter),
`ifdef COUNTER_AUTOINC_EN
    .load(load),
`endif
    .busy(busy10), .done(done10), .code_bcd(code10));

  always @(posedge clk) if (done6) ndone <= ndone + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] sha1(input bytes_t msg);
    bytes_t            m;
    logic [31:0]       h[5];
    logic [31:0]       w[80];
    logic [31:0]       a, b, c, d, e, f, kk, t;
    longint unsigned   nbits;
    m = msg;
    nbits = 64'(msg.size()) * 64'd8;
    m.push_back(8'h80);
    while (m.size() % 64 != 56) m.push_back(8'h00);
    for (int i = 7; i >= 0; i--) m.push_back(8'(nbits >> (8 * i)));
    h[0] = 32'h67452301; h[1] = 32'hEFCDAB89; h[2] = 32'h98BADCFE;
    h[3] = 32'h10325476; h[4] = 32'hC3D2E1F0;
    for (int n = 0; n < m.size() / 64; n++) begin
      for (int i = 0; i < 16; i++)
        w[i] = {m[64*n+4*i], m[64*n+4*i+1], m[64*n+4*i+2], m[64*n+4*i+3]};
      for (int i = 16; i < 80; i++) begin
        t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
        w[i] = (t << 1) | (t >> 31);
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4];
      for (int i = 0; i < 80; i++) begin
        case (i / 20)
          0:       begin f = (b & c) | (~b & d);          kk = 32'h5A827999; end
          1:       begin f = b ^ c ^ d;                   kk = 32'h6ED9EBA1; end
          2:       begin f = (b & c) | (b & d) | (c & d); kk = 32'h8F1BBCDC; end
          default: begin f = b ^ c ^ d;                   kk = 32'hCA62C1D6; end
        endcase
        t = ((a << 5) | (a >> 27)) + f + e + kk + w[i];
        e = d; d = c; c = (b << 30) | (b >> 2); b = a; a = t;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e;
    end
    return {h[0], h[1], h[2], h[3], h[4]};
  endfunction

  // Full ten-digit BCD of the truncated HOTP value; shorter codes are its low digits.
  function automatic logic [39:0] hotp_ref(input logic [511:0] k, input logic [63:0] c);
    bytes_t          ib, ob;
    logic [159:0]    ih, hm;
    byte unsigned    hb[20];
    byte unsigned    kb;
    int              off;
    longint unsigned bin;
    logic [39:0]     bcd;
    for (int i = 0; i < 64; i++) begin
      kb = k[511-8*i -: 8];
      ib.push_back(kb ^ 8'h36);
      ob.push_back(kb ^ 8'h5c);
    end
    for (int i = 7; i >= 0; i--) ib.push_back(c[8*i +: 8]);
    ih = sha1(ib);
    for (int i = 0; i < 20; i++) ob.push_back(ih[159-8*i -: 8]);
    hm = sha1(ob);
    for (int i = 0; i < 20; i++) hb[i] = hm[159-8*i -: 8];
    off = int'(hb[19] & 8'h0f);
    bin = {33'd0, hb[off][6:0], hb[off+1], hb[off+2], hb[off+3]};
    for (int i = 0; i < 10; i++) begin
      bcd[4*i +: 4] = 4'(bin % 10);
      bin = bin / 10;
    end
    return bcd;
  endfunction

  // One request; inj >= 0 pulses start (with another counter) that many cycles into the run.
  task automatic do_req(input logic [511:0] k, input logic [63:0] c, input bit ld,
                        input int inj, input string tag);
    int          cyc;
    int          nd0;
    logic [39:0] exp;
    exp = hotp_ref(k, c);
    nd0 = ndone;
    @(negedge clk);
    key = k; counter = c; start = 1'b1; load = ld;
    @(negedge clk);
    start = 1'b0; load = 1'b0;
    key = {16{$urandom()}}; counter = {$urandom(), $urandom()};
    cyc = 0;
    while (busy6 && cyc < 1000) begin
      if (cyc == inj) begin
        start = 1'b1; counter = c + 64'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(cyc), 64'(BUSY_CYCLES));
    chk({tag, "_done_all"}, {61'd0, done6, done8, done10}, 64'd7);
    chk({tag, "_code6"}, 64'(code6), 64'(exp[23:0]));
    chk({tag, "_code8"}, 64'(code8), 64'(exp[31:0]));
    chk({tag, "_code10"}, 64'(code10), 64'(exp));
    @(negedge clk);
    chk({tag, "_one_pulse"}, 64'(ndone - nd0), 64'd1);
    chk({tag, "_done_low"}, 64'(done6), 64'd0);
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int nd0;
    logic [511:0] rk;
    logic [63:0]  rc;
    rfc = {RFC_KEY, 352'd0};
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy6), 64'd0);
    chk("reset_done", 64'(done6), 64'd0);
    chk("reset_code10", 64'(code10), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(rfc, 64'd0, 1'b1, -1, "t1");
    chk("t1_rfc6", 64'(code6), 64'h755224);
    chk("t3_rfc8", 64'(code8), 64'h84755224);
    do_req(rfc, 64'd1, 1'b1, -1, "t2a");
    chk("t2_rfc_c1", 64'(code6), 64'h287082);
    chk("t3_rfc10", 64'(code10), 64'h1094287082);
    do_req(rfc, 64'd9, 1'b1, -1, "t2b");
    chk("t2_rfc_c9", 64'(code6), 64'h520489);

    do_req(rfc, 64'd0, 1'b1, 5, "t4");
    chk("t4_ignored_start", 64'(code6), 64'h755224);

    // Abort during CONV: outputs clear immediately and no done follows.
    @(negedge clk);
    key = rfc; counter = 64'd1; start = 1'b1; load = 1'b1;
    @(negedge clk);
    start = 1'b0; load = 1'b0;
    repeat (340) @(negedge clk);
    nd0 = ndone;
    rst_n = 1'b0;
    #1;
    chk("t5_abort_busy", 64'(busy6), 64'd0);
    chk("t5_abort_code", 64'(code6), 64'd0);
    chk("t5_abort_code10", 64'(code10), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("t5_no_done", 64'(ndone - nd0), 64'd0);
    do_req(rfc, 64'd9, 1'b1, -1, "t5");
    chk("t5_after_reset", 64'(code6), 64'h520489);

    // start held high across DONE: re-accepted on the first IDLE cycle.
    @(negedge clk);
    key = rfc; counter = 64'd0; start = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0; counter = 64'd1;
    cyc = 0;
    while (!done6 && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("hold_first", 64'(code6), 64'h755224);
    @(negedge clk);
    chk("hold_idle_gap", 64'(busy6), 64'd0);
    @(negedge clk);
    chk("hold_reaccept", 64'(busy6), 64'd1);
    start = 1'b0;
    cyc = 0;
    while (!done6 && cyc < 1000) begin @(negedge clk); cyc++; end
    chk("hold_second", 64'(code6), 64'h287082);
    @(negedge clk);

`ifdef COUNTER_AUTOINC_EN
    @(negedge clk);
    counter = 64'd0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    do_req(rfc, 64'd0, 1'b0, -1, "t6a");
    do_req(rfc, 64'd1, 1'b0, -1, "t6b");
    do_req(rfc, 64'd2, 1'b0, -1, "t6c");
    chk("t6_rfc_c2", 64'(code6), 64'h359152);
    do_req(rfc, 64'd3, 1'b0, -1, "t6d");
`endif

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 16; j++) rk[32*j +: 32] = $urandom();
      rc = {$urandom(), $urandom()};
      do_req(rk, rc, 1'b1, -1, $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
